hex_display_writer: RTL and testbench

Avalon-MM master that drives the seven-segment hex PIO output ports of the DNN accelerator system. It accepts a packed hexadecimal value through a valid/ready handshake, encodes each nibble as an active-low 7-segment pattern, and writes one pattern per display to consecutive hex PIO slaves through the interconnect, honouring waitrequest. It lets accelerator datapath logic show results without Nios software.

---
 rtl/hex_display_writer.sv | 154 +++++++++++++++
 tb/tb_hex_display_writer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hex_display_writer.sv
// rtl/hex_display_writer.sv - Avalon-MM master writing 7-segment patterns to hex PIO slaves
module hex_display_writer #(
  parameter int          NUM_DIGITS  = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          ADDR_STRIDE = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic [4*NUM_DIGITS-1:0] value_data,
  input  logic                    blank_lz,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             avm_address,
  output logic                    avm_write,
  output logic [31:0]             avm_writedata,
  output logic [3:0]              avm_byteenable,
  input  logic                    avm_waitrequest
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [31:0]      STRIDE   = 32'(ADDR_STRIDE);
  localparam logic [6:0]       SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_next;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [4*NUM_DIGITS-1:0] w_value_next;
  logic                    r_blank;
  logic                    w_blank_next;
  logic [31:0]             r_address;
  logic [31:0]             w_address_next;
  logic [31:0]             r_writedata;
  logic [31:0]             w_writedata_next;
  logic [IDX_W-1:0]        w_idx_inc;

  // Active-low segment pattern, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0:    seg7 = 7'h40;
      4'h1:    seg7 = 7'h79;
      4'h2:    seg7 = 7'h24;
      4'h3:    seg7 = 7'h30;
      4'h4:    seg7 = 7'h19;
      4'h5:    seg7 = 7'h12;
      4'h6:    seg7 = 7'h02;
      4'h7:    seg7 = 7'h78;
      4'h8:    seg7 = 7'h00;
      4'h9:    seg7 = 7'h10;
      4'hA:    seg7 = 7'h08;
      4'hB:    seg7 = 7'h03;
      4'hC:    seg7 = 7'h46;
      4'hD:    seg7 = 7'h21;
      4'hE:    seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Pattern for digit i; a digit above 0 is blanked when it and every higher nibble is zero.
  function automatic logic [6:0] digit_seg(input logic [4*NUM_DIGITS-1:0] v,
                                           input logic blank, input int i);
    logic       upper_zero;
    logic [3:0] nib;
    upper_zero = 1'b1;
    nib        = 4'h0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j == i) nib = v[4*j +: 4];
      if ((j >= i) && (v[4*j +: 4] != 4'h0)) upper_zero = 1'b0;
    end
    if (blank && (i != 0) && upper_zero) digit_seg = SEG_BLANK;
    else                                 digit_seg = seg7(nib);
  endfunction

  assign w_idx_inc = r_idx + IDX_ONE;

  // State and datapath registers; reset abandons any write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_value     <= '0;
      r_blank     <= 1'b0;
      r_address   <= BASE_ADDR;
      r_writedata <= {25'b0, SEG_BLANK};
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_value     <= w_value_next;
      r_blank     <= w_blank_next;
      r_address   <= w_address_next;
      r_writedata <= w_writedata_next;
    end
  end

  // Next-state logic: accept in IDLE, step through digits in WRITE, pulse DONE once.
  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_value_next     = r_value;
    w_blank_next     = r_blank;
    w_address_next   = r_address;
    w_writedata_next = r_writedata;
    case (r_state)
      S_IDLE: begin
        if (value_valid) begin
          w_state_next     = S_WRITE;
          w_idx_next       = '0;
          w_value_next     = value_data;
          w_blank_next     = blank_lz;
          w_address_next   = BASE_ADDR;
          // Digit 0 is never blanked, so its pattern comes straight from the input.
          w_writedata_next = {25'b0, seg7(value_data[3:0])};
        end
      end
      S_WRITE: begin
        if (!avm_waitrequest) begin
          if (r_idx == LAST_IDX) begin
            w_state_next = S_DONE;
          end else begin
            w_idx_next       = w_idx_inc;
            w_address_next   = r_address + STRIDE;
            w_writedata_next = {25'b0, digit_seg(r_value, r_blank, int'(w_idx_inc))};
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign value_ready    = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign avm_write      = (r_state == S_WRITE);
  assign avm_address    = r_address;
  assign avm_writedata  = r_writedata;
  assign avm_byteenable = 4'hF;

endmodule

// File: tb/tb_hex_display_writer.sv
// tb/tb_hex_display_writer.sv - directed bench for hex_display_writer
module tb_hex_display_writer;

  logic clk;
  logic reset_n;

  logic        v_valid, v_ready, v_blz, v_busy, v_done, v_write, v_wait;
  logic [23:0] v_data;
  logic [31:0] v_addr, v_wdata;
  logic [3:0]  v_be;

  logic        p1_valid, p1_ready, p1_busy, p1_done, p1_write;
  logic [3:0]  p1_data;
  logic [31:0] p1_addr, p1_wdata;
  logic [3:0]  p1_be;

  logic        p2_valid, p2_ready, p2_busy, p2_done, p2_write;
  logic [7:0]  p2_data;
  logic [31:0] p2_addr, p2_wdata;
  logic [3:0]  p2_be;

  int n_vec  = 0;
  int n_miss = 0;

  hex_display_writer u_dut (
    .clk(clk), .reset_n(reset_n),
    .value_valid(v_valid), .value_ready(v_ready), .value_data(v_data), .blank_lz(v_blz),
    .busy(v_busy), .done(v_done),
    .avm_address(v_addr), .avm_write(v_write), .avm_writedata(v_wdata),
    .avm_byteenable(v_be), .avm_waitrequest(v_wait)
  );

  hex_display_writer #(.NUM_DIGITS(1), .BASE_ADDR(32'hFFFF_FFFC), .ADDR_STRIDE(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .value_valid(p1_valid), .value_ready(p1_ready), .value_data(p1_data), .blank_lz(1'b0),
    .busy(p1_busy), .done(p1_done),
    .avm_address(p1_addr), .avm_write(p1_write), .avm_writedata(p1_wdata),
    .avm_byteenable(p1_be), .avm_waitrequest(1'b0)
  );

  hex_display_writer #(.NUM_DIGITS(2), .BASE_ADDR(32'hFFFF_FFFC), .ADDR_STRIDE(4)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .value_valid(p2_valid), .value_ready(p2_ready), .value_data(p2_data), .blank_lz(1'b0),
    .busy(p2_busy), .done(p2_done),
    .avm_address(p2_addr), .avm_write(p2_write), .avm_writedata(p2_wdata),
    .avm_byteenable(p2_be), .avm_waitrequest(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full sequence on the default instance; exp holds digit 0 pattern in the top byte.
  task automatic run_seq(input string tag, input logic [23:0] val, input logic blz,
                         input logic [47:0] exp, input int stall_digit, input int stall_n);
    int ns;
    logic [7:0] eb;
    check({tag, " ready"}, {31'b0, v_ready}, 32'd1);
    v_data  = val;
    v_blz   = blz;
    v_valid = 1'b1;
    @(negedge clk);
    v_valid = 1'b0;
    v_data  = ~val;
    v_blz   = ~blz;
    for (int i = 0; i < 6; i++) begin
      ns = (i == stall_digit) ? stall_n : 0;
      eb = exp[47-8*i -: 8];
      for (int s = 0; s <= ns; s++) begin
        check($sformatf("%s d%0d s%0d write", tag, i, s), {31'b0, v_write}, 32'd1);
        check($sformatf("%s d%0d s%0d addr", tag, i, s), v_addr, 32'h1000 + 32'(i*16));
        check($sformatf("%s d%0d s%0d data", tag, i, s), v_wdata, {24'h0, eb});
        check($sformatf("%s d%0d s%0d rdy/done/busy", tag, i, s),
              {29'b0, v_ready, v_done, v_busy}, 32'b001);
        v_wait = (s < ns);
        @(negedge clk);
      end
    end
    v_wait = 1'b1;
    check({tag, " done"}, {29'b0, v_ready, v_done, v_busy}, 32'b011);
    check({tag, " done write"}, {31'b0, v_write}, 32'd0);
    @(negedge clk);
    v_wait = 1'b0;
    check({tag, " idle"}, {29'b0, v_ready, v_done, v_busy}, 32'b100);
    check({tag, " idle write"}, {31'b0, v_write}, 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    v_valid  = 1'b0; v_data = '0; v_blz = 1'b0; v_wait = 1'b0;
    p1_valid = 1'b0; p1_data = '0;
    p2_valid = 1'b0; p2_data = '0;
    repeat (3) @(negedge clk);
    check("rst write", {31'b0, v_write}, 32'd0);
    check("rst wdata", v_wdata, 32'h7F);
    check("rst addr", v_addr, 32'h1000);
    check("rst be", {28'b0, v_be}, 32'hF);
    check("rst busy/done", {30'b0, v_busy, v_done}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post rst ready", {31'b0, v_ready}, 32'd1);

    run_seq("s12AB3F", 24'h12AB3F, 1'b0, 48'h0E_30_03_08_24_79, -1, 0);
    run_seq("stall", 24'h12AB3F, 1'b0, 48'h0E_30_03_08_24_79, 2, 3);
    run_seq("lzA0", 24'h0000A0, 1'b1, 48'h40_08_7F_7F_7F_7F, -1, 0);
    run_seq("lz0", 24'h000000, 1'b1, 48'h40_7F_7F_7F_7F_7F, -1, 0);
    run_seq("nolz0", 24'h000000, 1'b0, 48'h40_40_40_40_40_40, -1, 0);
    run_seq("lzmid", 24'h100200, 1'b1, 48'h40_40_24_40_40_79, -1, 0);
    run_seq("s456789", 24'h456789, 1'b0, 48'h10_00_78_02_12_19, -1, 0);
    run_seq("s0EDC00", 24'h0EDC00, 1'b0, 48'h40_40_46_21_06_40, -1, 0);

    // Back-to-back with value_valid held high.
    v_data = 24'h111111; v_blz = 1'b0; v_valid = 1'b1;
    @(negedge clk);
    v_data = 24'hFFFFFF;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("b2b1 d%0d data", i), v_wdata, 32'h79);
      check($sformatf("b2b1 d%0d write/ready", i), {30'b0, v_write, v_ready}, 32'b10);
      @(negedge clk);
    end
    check("b2b1 done", {30'b0, v_done, v_ready}, 32'b10);
    @(negedge clk);
    check("b2b ready gap", {30'b0, v_ready, v_write}, 32'b10);
    @(negedge clk);
    v_data = 24'h000000;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("b2b2 d%0d addr", i), v_addr, 32'h1000 + 32'(i*16));
      check($sformatf("b2b2 d%0d data", i), v_wdata, 32'h0E);
      @(negedge clk);
    end
    check("b2b2 done", {31'b0, v_done}, 32'd1);
    v_valid = 1'b0;
    @(negedge clk);
    check("b2b2 idle", {30'b0, v_ready, v_write}, 32'b10);

    // Reset in the middle of digit 3.
    v_data = 24'h654321; v_valid = 1'b1;
    @(negedge clk);
    v_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-rst addr", v_addr, 32'h1030);
    reset_n = 1'b0;
    #1;
    check("rst mid write", {31'b0, v_write}, 32'd0);
    check("rst mid busy", {31'b0, v_busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("after rst c%0d write", c), {31'b0, v_write}, 32'd0);
      check($sformatf("after rst c%0d rdy/busy", c), {30'b0, v_ready, v_busy}, 32'b10);
      check($sformatf("after rst c%0d wdata", c), v_wdata, 32'h7F);
      @(negedge clk);
    end

    // Single digit instance.
    p1_data = 4'h7; p1_valid = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0;
    check("p1 write", {31'b0, p1_write}, 32'd1);
    check("p1 addr", p1_addr, 32'hFFFF_FFFC);
    check("p1 data", p1_wdata, 32'h78);
    @(negedge clk);
    check("p1 done", {29'b0, p1_write, p1_done, p1_busy}, 32'b011);
    @(negedge clk);
    check("p1 idle", {30'b0, p1_ready, p1_done}, 32'b10);

    // Two digit instance: second write wraps to address 0.
    p2_data = 8'h5A; p2_valid = 1'b1;
    @(negedge clk);
    p2_valid = 1'b0;
    check("p2 d0 addr", p2_addr, 32'hFFFF_FFFC);
    check("p2 d0 data", p2_wdata, 32'h08);
    @(negedge clk);
    check("p2 d1 write", {31'b0, p2_write}, 32'd1);
    check("p2 d1 addr", p2_addr, 32'h0000_0000);
    check("p2 d1 data", p2_wdata, 32'h12);
    @(negedge clk);
    check("p2 done", {30'b0, p2_done, p2_write}, 32'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
